// File: rtl/tlx_dlx_flit_tx_credit.sv
// -----------------------------------------------------------------------------
// tlx_dlx_flit_tx_credit
//
// Upstream transmit stage for the DLx. Flits from the TLX framer are buffered
// in a small FIFO. A flit is released to the DLx only when a transmit credit
// is available. The initial credit count is loaded from
// dlx_tlx_init_flit_depth at link-up. Credits are then replenished by
// single-cycle dlx_tlx_flit_credit pulses. All logic runs on the rising edge
// of tx_clk_402MHz.
//
// Ports
//   tx_clk_402MHz            in   clock
//   reset_n                  in   asynchronous active-low reset
//   dlx_tlx_link_up          in   DLx training complete (level)
//   dlx_tlx_init_flit_depth  in   initial credit count, sampled in LOAD
//   dlx_tlx_flit_credit      in   1-cycle pulse, one credit returned
//   tl_flit / tl_flit_valid  in   flit offered by the framer
//   tl_flit_ready            out  flit is accepted on this edge if valid
//   tlx_dlx_flit             out  flit to the DLx (holds its last value)
//   tlx_dlx_flit_valid       out  1-cycle strobe per issued flit
//   credit_count             out  credits currently available
//   fifo_level               out  occupied FIFO entries
//   credit_ovf_err           out  sticky: credit returned while at MAX_CRED
// -----------------------------------------------------------------------------
module tlx_dlx_flit_tx_credit #(
  parameter int FLIT_W     = 512,
  parameter int FIFO_DEPTH = 8,   // power of 2, >= 2
  parameter int CNT_W      = 4    // must hold 7 + 1 for the LOAD-cycle pulse
) (
  input  logic                          tx_clk_402MHz,
  input  logic                          reset_n,
  input  logic                          dlx_tlx_link_up,
  input  logic [2:0]                    dlx_tlx_init_flit_depth,
  input  logic                          dlx_tlx_flit_credit,
  input  logic [FLIT_W-1:0]             tl_flit,
  input  logic                          tl_flit_valid,
  output logic                          tl_flit_ready,
  output logic [FLIT_W-1:0]             tlx_dlx_flit,
  output logic                          tlx_dlx_flit_valid,
  output logic [CNT_W-1:0]              credit_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          credit_ovf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CRED = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [FLIT_W-1:0]  flit_q;
  logic               flit_valid_q;
  logic [FLIT_W-1:0]  mem_q [FIFO_DEPTH];

  logic run;
  logic flush;
  logic push;
  logic issue;

  assign run   = (state_q == ST_RUN);
  // A link drop in RUN flushes everything on the same edge. Issue is
  // suppressed there so that no strobe leaves during the drop.
  assign flush = run && !dlx_tlx_link_up;

  assign tl_flit_ready = run && (level_q < LVL_W'(FIFO_DEPTH));
  assign push          = tl_flit_valid && tl_flit_ready;
  assign issue         = run && dlx_tlx_link_up && (level_q != '0) && (credit_q != '0);

  // ---------------------------------------------------------------------------
  // FSM next state and credit arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d  = state_q;
    credit_d = credit_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        credit_d = '0;          // credit pulses are ignored until link-up
        if (dlx_tlx_link_up) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        credit_d = CNT_W'(dlx_tlx_init_flit_depth) + CNT_W'(dlx_tlx_flit_credit);
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (!dlx_tlx_link_up) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end else if (dlx_tlx_flit_credit && !issue) begin
          if (credit_q == MAX_CRED) ovf_d = 1'b1;   // saturate, flag the overflow
          else                      credit_d = credit_q + CNT_W'(1);
        end else if (!dlx_tlx_flit_credit && issue) begin
          credit_d = credit_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge tx_clk_402MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and level (pointers wrap naturally, FIFO_DEPTH is 2**PTR_W)
  // ---------------------------------------------------------------------------
  always_ff @(posedge tx_clk_402MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !issue)      level_q <= level_q + LVL_W'(1);
      else if (!push && issue) level_q <= level_q - LVL_W'(1);
    end
  end

  // NOTE: the storage array has no reset. Its contents are only read
  // behind level_q, which is reset, so clearing 4 kbit of flops buys nothing.
  always_ff @(posedge tx_clk_402MHz) begin
    if (push) mem_q[wr_ptr_q] <= tl_flit;
  end

  // ---------------------------------------------------------------------------
  // Output register: valid is a 1-cycle strobe, data holds between strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge tx_clk_402MHz or negedge reset_n) begin
    if (!reset_n) begin
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      flit_valid_q <= issue;
      if (issue) flit_q <= mem_q[rd_ptr_q];
    end
  end

  assign tlx_dlx_flit       = flit_q;
  assign tlx_dlx_flit_valid = flit_valid_q;
  assign credit_count       = credit_q;
  assign fifo_level         = level_q;
  assign credit_ovf_err     = ovf_q;

endmodule

// File: tb/tb_tlx_dlx_flit_tx_credit.sv
// -----------------------------------------------------------------------------
// tb_tlx_dlx_flit_tx_credit
//
// Directed scenarios followed by a randomized run. The expected output
// values come from a transaction-level model. The model keeps a queue of
// flits, an integer credit balance and the link phase. It is stepped once
// per clock edge with the same inputs as the DUT. Inputs change 1 time unit
// after the rising edge. Outputs are compared at that same point.
// -----------------------------------------------------------------------------
module tb_tlx_dlx_flit_tx_credit;

  localparam int FLIT_W = 512;
  localparam int DEPTH  = 8;
  localparam int MAXC   = 15;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              link;
  logic [2:0]        depth;
  logic              pulse;
  logic [FLIT_W-1:0] flit;
  logic              fvalid;
  logic              ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic [3:0]        credit_count;
  logic [3:0]        fifo_level;
  logic              ovf;

  tlx_dlx_flit_tx_credit dut (
    .tx_clk_402MHz          (clk),
    .reset_n                (reset_n),
    .dlx_tlx_link_up        (link),
    .dlx_tlx_init_flit_depth(depth),
    .dlx_tlx_flit_credit    (pulse),
    .tl_flit                (flit),
    .tl_flit_valid          (fvalid),
    .tl_flit_ready          (ready),
    .tlx_dlx_flit           (out_flit),
    .tlx_dlx_flit_valid     (out_valid),
    .credit_count           (credit_count),
    .fifo_level             (fifo_level),
    .credit_ovf_err         (ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  int                m_phase;
  logic [FLIT_W-1:0] m_q[$];
  int                m_cred;
  bit                m_ovf;
  bit                m_valid;
  logic [FLIT_W-1:0] m_flit;

  int  errors  = 0;
  int  checks  = 0;
  int  strobes = 0;
  int  to_send = 0;
  bit  rand_mode = 1'b0;

  task automatic check(input string tag, input logic [FLIT_W-1:0] got,
                       input logic [FLIT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] rand_flit();
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < FLIT_W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // One clock edge: step the model, let the DUT clock, compare, update driver.
  task automatic tick();
    bit acc;
    bit iss;
    acc = fvalid && (m_phase == P_RUN) && (m_q.size() < DEPTH);
    iss = 1'b0;
    case (m_phase)
      P_IDLE: begin
        m_cred  = 0;
        m_valid = 1'b0;
        if (link) m_phase = P_LOAD;
      end
      P_LOAD: begin
        m_cred  = int'(depth) + int'(pulse);
        m_valid = 1'b0;
        m_phase = P_RUN;
      end
      default: begin
        if (!link) begin
          m_q.delete();
          m_cred  = 0;
          m_valid = 1'b0;
          m_phase = P_IDLE;
        end else begin
          iss = (m_q.size() != 0) && (m_cred != 0);
          if (iss) m_flit = m_q.pop_front();
          m_valid = iss;
          if (acc) m_q.push_back(flit);
          if (pulse && !iss && m_cred == MAXC) m_ovf = 1'b1;
          else m_cred = m_cred + int'(pulse) - int'(iss);
        end
      end
    endcase

    @(posedge clk);
    #1;
    check("valid",  out_valid,    m_valid);
    check("flit",   out_flit,     m_flit);
    check("credit", credit_count, m_cred);
    check("level",  fifo_level,   m_q.size());
    check("ovf",    ovf,          m_ovf);
    check("ready",  ready,        (m_phase == P_RUN) && (m_q.size() < DEPTH));
    if (out_valid) strobes++;

    // Driver: tl_flit is held until accepted, then replaced.
    if (acc) begin
      flit = rand_flit();
      if (rand_mode) fvalid = ($urandom_range(0, 2) != 0);
      else begin
        to_send--;
        fvalid = (to_send > 0);
      end
    end else if (rand_mode && !fvalid) begin
      fvalid = $urandom_range(0, 1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int n);
    to_send = n;
    fvalid  = (n > 0);
  endtask

  task automatic pulse_once();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    link    = 1'b0;
    depth   = '0;
    pulse   = 1'b0;
    fvalid  = 1'b0;
    flit    = rand_flit();
    m_phase = P_IDLE;
    m_cred  = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_flit  = '0;

    #22;
    check("rst_valid",  out_valid,    1'b0);
    check("rst_flit",   out_flit,     '0);
    check("rst_credit", credit_count, 4'd0);
    check("rst_level",  fifo_level,   4'd0);
    check("rst_ovf",    ovf,          1'b0);
    check("rst_ready",  ready,        1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: depth 3, five flits back-to-back -> three strobes, two left queued
    link = 1'b1; depth = 3'd3; strobes = 0;
    send(5);
    run(14);
    check("t1_strobes", strobes,      3);
    check("t1_credit",  credit_count, 4'd0);
    check("t1_level",   fifo_level,   4'd2);

    // 2: two returned credits drain the remaining flits in order
    strobes = 0;
    pulse_once();
    run(1);
    pulse_once();
    run(6);
    check("t2_strobes", strobes,      2);
    check("t2_credit",  credit_count, 4'd0);
    check("t2_level",   fifo_level,   4'd0);

    // 3: latency of a single flit with credits available
    link = 1'b0; run(1);
    depth = 3'd7; link = 1'b1; run(2);
    check("t3_load", credit_count, 4'd7);
    send(1);
    tick();
    check("t3_edge_k",   out_valid, 1'b0);
    tick();
    check("t3_edge_k1",  out_valid, 1'b1);
    check("t3_credit",   credit_count, 4'd6);
    tick();
    check("t3_edge_k2",  out_valid, 1'b0);

    // 4: saturate at MAX_CRED, overflow is sticky across link drop
    pulse = 1'b1; run(9); pulse = 1'b0;
    check("t4_max",     credit_count, 4'd15);
    check("t4_no_ovf",  ovf,          1'b0);
    pulse_once();
    check("t4_sat",     credit_count, 4'd15);
    check("t4_ovf",     ovf,          1'b1);
    link = 1'b0; run(2);
    check("t4_ovf_keep", ovf,          1'b1);
    check("t4_drop_cr",  credit_count, 4'd0);

    // 5: full FIFO with no credits, then one credit while a flit is waiting
    depth = 3'd0; link = 1'b1; run(2);
    send(8);
    run(10);
    check("t5_full",     fifo_level, 4'd8);
    check("t5_notready", ready,      1'b0);
    strobes = 0;
    send(1);
    pulse_once();
    run(4);
    check("t5_strobes",  strobes,      1);
    check("t5_level",    fifo_level,   4'd8);
    check("t5_credit",   credit_count, 4'd0);

    // 6: link drop with flits queued and a credit pending -> nothing sent
    link = 1'b0; tick();
    depth = 3'd0; link = 1'b1; run(2);
    send(4);
    run(6);
    check("t6_queued", fifo_level, 4'd4);
    pulse_once();
    check("t6_cred1",  credit_count, 4'd1);
    strobes = 0;
    link = 1'b0; tick();
    check("t6_level",  fifo_level,   4'd0);
    check("t6_credit", credit_count, 4'd0);
    check("t6_valid",  out_valid,    1'b0);
    run(2);
    check("t6_nostrobe", strobes, 0);
    depth = 3'd1; link = 1'b1; run(2);
    check("t6_relink", credit_count, 4'd1);

    // Randomized traffic, credits and occasional link drops
    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      pulse = ($urandom_range(0, 3) == 0);
      if (link && $urandom_range(0, 199) == 0) link = 1'b0;
      else if (!link && $urandom_range(0, 3) == 0) begin
        link  = 1'b1;
        depth = 3'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
